// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: the bubble instruction, the
// default reset fetch address, the default stall-depth limit and the FSM
// state encoding.
package fetch_stage_pkg;

  // addi x0,x0,0
  localparam logic [31:0] DEFAULT_NOP_INST  = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam int          DEFAULT_MAX_STALL = 3;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_FLUSH = 2'd3
  } fetch_state_e;

  // Instruction fetches are word aligned; low address bits are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Holds the instruction handed to decode together
// with its PC, PC+4 and a valid bit.
//   clk, rst          : clock, synchronous active-high reset
//   flush_i           : load a bubble (NOP, pc 0, pc+4 4, valid 0)
//   load_i            : capture inst_i / pc_i / pc_plus4_i, valid 1
//   (neither)         : hold
//   inst_o, pc_o, pc_plus4_o, valid_o : registered fields
module fetch_stage_if_id_reg #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        load_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pc_plus4_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o
);

  logic [31:0] inst_q, pc_q, pc_plus4_q;
  logic        valid_q;

  // Flush wins over load so a redirect always leaves a bubble behind.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      inst_q     <= NOP_INST;
      pc_q       <= 32'h0000_0000;
      pc_plus4_q <= 32'h0000_0004;
      valid_q    <= 1'b0;
    end else if (load_i) begin
      inst_q     <= inst_i;
      pc_q       <= pc_i;
      pc_plus4_q <= pc_plus4_i;
      valid_q    <= 1'b1;
    end
  end

  assign inst_o     = inst_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage of the 5-stage RV32I core: PC register, IF/ID register,
// fetch FSM and a watchdog on the length of data-hazard stalls.
//   clk, rst            : clock, synchronous active-high reset
//   inst_i              : instruction read combinationally at pc_o
//   data_stall_flag     : hold PC and IF/ID this cycle
//   redirect_valid/_pc  : taken branch/jump from EXE, flushes IF/ID
//   pc_o                : fetch address
//   if_id_*_o           : instruction, PC, PC+4 and valid presented to ID
//   stall_err_o         : sticky, a stall run exceeded MAX_STALL
// Build option FETCH_PERF_CNT_EN adds perf_fetch_cnt_o, perf_stall_cnt_o
// and perf_flush_cnt_o (fetches, stall edges, redirect edges).
//
// state | meaning
// BOOT  | first cycle after reset, PC held, IF/ID bubble
// RUN   | normal fetch
// STALL | previous edge was a data stall, PC and IF/ID held
// FLUSH | previous edge took a redirect, fetches like RUN
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INST  = DEFAULT_NOP_INST,
  parameter int          MAX_STALL = DEFAULT_MAX_STALL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_i,
  input  logic        data_stall_flag,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_o,
  output logic [31:0] if_id_inst_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_pc_plus4_o,
  output logic        if_id_valid_o,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_fetch_cnt_o,
  output logic [31:0] perf_stall_cnt_o,
  output logic [31:0] perf_flush_cnt_o,
`endif
  output logic        stall_err_o
);

  // Counter saturates at MAX_STALL+1, the first illegal run length.
  localparam int              CNT_W     = $clog2(MAX_STALL + 2);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_STALL + 1);

  fetch_state_e state_q, state_d;

  logic [31:0]      pc_q, pc_d, pc_plus4;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             stall_err_q, stall_err_d;

  logic ifid_flush, ifid_load, stall_edge, redirect_edge;

  assign pc_plus4 = pc_q + 32'd4;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_BOOT;
    else     state_q <= state_d;
  end

  // Next state: RUN, STALL and FLUSH all follow the same transition rules.
  always_comb begin
    state_d = ST_RUN;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      default: begin
        if (redirect_valid)       state_d = ST_FLUSH;
        else if (data_stall_flag) state_d = ST_STALL;
        else                      state_d = ST_RUN;
      end
    endcase
  end

  // Per-edge actions, priority redirect > stall > normal fetch.
  always_comb begin
    pc_d          = pc_q;
    ifid_flush    = 1'b0;
    ifid_load     = 1'b0;
    stall_edge    = 1'b0;
    redirect_edge = 1'b0;
    if (state_q == ST_BOOT) begin
      ifid_flush = 1'b1;
    end else if (redirect_valid) begin
      redirect_edge = 1'b1;
      ifid_flush    = 1'b1;
      pc_d          = align_word(redirect_pc);
    end else if (data_stall_flag) begin
      stall_edge = 1'b1;
    end else begin
      ifid_load = 1'b1;
      pc_d      = pc_plus4;
    end
  end

  always_comb begin
    stall_cnt_d = '0;
    stall_err_d = stall_err_q;
    if (stall_edge) begin
      if (stall_cnt_q != CNT_LIMIT) stall_cnt_d = stall_cnt_q + 1'b1;
      else                          stall_cnt_d = stall_cnt_q;
      if (stall_cnt_d == CNT_LIMIT) stall_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      stall_cnt_q <= '0;
      stall_err_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      stall_cnt_q <= stall_cnt_d;
      stall_err_q <= stall_err_d;
    end
  end

  fetch_stage_if_id_reg #(
    .NOP_INST(NOP_INST)
  ) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (ifid_flush),
    .load_i     (ifid_load),
    .inst_i     (inst_i),
    .pc_i       (pc_q),
    .pc_plus4_i (pc_plus4),
    .inst_o     (if_id_inst_o),
    .pc_o       (if_id_pc_o),
    .pc_plus4_o (if_id_pc_plus4_o),
    .valid_o    (if_id_valid_o)
  );

  assign pc_o        = pc_q;
  assign stall_err_o = stall_err_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_stall_q, perf_flush_q;

  // Action strobes are already zero during BOOT, so BOOT is never counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (ifid_load)     perf_fetch_q <= perf_fetch_q + 32'd1;
      if (stall_edge)    perf_stall_q <= perf_stall_q + 32'd1;
      if (redirect_edge) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_fetch_cnt_o = perf_fetch_q;
  assign perf_stall_cnt_o = perf_stall_q;
  assign perf_flush_cnt_o = perf_flush_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] SALT = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] rpc = 32'h0;

  logic [31:0] pc, inst, if_inst, if_pc, if_pc4;
  logic        if_valid, err;
  logic [31:0] w_pc, w_inst, w_if_inst, w_if_pc, w_if_pc4;
  logic        w_valid, w_err;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] pf_fetch, pf_stall, pf_flush;
  logic [31:0] w_pf_fetch, w_pf_stall, w_pf_flush;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Combinational instruction memory
  assign inst   = pc ^ SALT;
  assign w_inst = w_pc ^ SALT;

  fetch_stage dut (
    .clk(clk), .rst(rst), .inst_i(inst), .data_stall_flag(stall),
    .redirect_valid(redir), .redirect_pc(rpc), .pc_o(pc),
    .if_id_inst_o(if_inst), .if_id_pc_o(if_pc), .if_id_pc_plus4_o(if_pc4),
    .if_id_valid_o(if_valid),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetch_cnt_o(pf_fetch), .perf_stall_cnt_o(pf_stall),
    .perf_flush_cnt_o(pf_flush),
`endif
    .stall_err_o(err)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst(rst), .inst_i(w_inst), .data_stall_flag(stall),
    .redirect_valid(redir), .redirect_pc(rpc), .pc_o(w_pc),
    .if_id_inst_o(w_if_inst), .if_id_pc_o(w_if_pc),
    .if_id_pc_plus4_o(w_if_pc4), .if_id_valid_o(w_valid),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetch_cnt_o(w_pf_fetch), .perf_stall_cnt_o(w_pf_stall),
    .perf_flush_cnt_o(w_pf_flush),
`endif
    .stall_err_o(w_err)
  );

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic d,
                      input logic [31:0] p);
    @(negedge clk);
    rst = r; stall = s; redir = d; rpc = p;
    @(posedge clk);
    #1;
  endtask

  // Reference model: the architectural effect of one clock edge.
  logic [31:0] m_pc, m_inst, m_ifpc;
  logic        m_valid, m_err, m_boot;
  int          m_run;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] m_pf_fetch, m_pf_stall, m_pf_flush;
`endif

  task automatic model_edge(input logic r, input logic s, input logic d,
                            input logic [31:0] p);
    if (r) begin
      m_pc = 32'h0; m_boot = 1'b1; m_err = 1'b0; m_run = 0;
      m_inst = NOP; m_ifpc = 32'h0; m_valid = 1'b0;
`ifdef FETCH_PERF_CNT_EN
      m_pf_fetch = 0; m_pf_stall = 0; m_pf_flush = 0;
`endif
    end else if (m_boot) begin
      m_boot = 1'b0; m_run = 0;
      m_inst = NOP; m_ifpc = 32'h0; m_valid = 1'b0;
    end else if (d) begin
      m_pc = {p[31:2], 2'b00}; m_run = 0;
      m_inst = NOP; m_ifpc = 32'h0; m_valid = 1'b0;
`ifdef FETCH_PERF_CNT_EN
      m_pf_flush++;
`endif
    end else if (s) begin
      m_run++;
      if (m_run > 3) m_err = 1'b1;
`ifdef FETCH_PERF_CNT_EN
      m_pf_stall++;
`endif
    end else begin
      m_inst = m_pc ^ SALT; m_ifpc = m_pc; m_valid = 1'b1;
      m_pc = m_pc + 32'd4; m_run = 0;
`ifdef FETCH_PERF_CNT_EN
      m_pf_fetch++;
`endif
    end
  endtask

  typedef struct {
    logic        r, s, d;
    logic [31:0] p;
    logic [31:0] e_pc, e_inst, e_ifpc;
    logic        e_valid, e_err;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic s, input logic d,
                              input logic [31:0] p, input logic [31:0] e_pc,
                              input logic [31:0] e_inst,
                              input logic [31:0] e_ifpc, input logic e_valid,
                              input logic e_err);
    vec_t v;
    v.r = r; v.s = s; v.d = d; v.p = p;
    v.e_pc = e_pc; v.e_inst = e_inst; v.e_ifpc = e_ifpc;
    v.e_valid = e_valid; v.e_err = e_err;
    return v;
  endfunction

  vec_t vecs[20];

  initial begin
    vecs[0]  = mk(1, 0, 0, 0,     32'h0,   NOP,          32'h0,   0, 0);
    vecs[1]  = mk(0, 1, 1, 32'h40, 32'h0,  NOP,          32'h0,   0, 0);
    vecs[2]  = mk(0, 0, 0, 0,     32'h4,   32'hA5A5_0000, 32'h0,  1, 0);
    vecs[3]  = mk(0, 0, 0, 0,     32'h8,   32'hA5A5_0004, 32'h4,  1, 0);
    vecs[4]  = mk(0, 1, 0, 0,     32'h8,   32'hA5A5_0004, 32'h4,  1, 0);
    vecs[5]  = mk(0, 1, 0, 0,     32'h8,   32'hA5A5_0004, 32'h4,  1, 0);
    vecs[6]  = mk(0, 1, 0, 0,     32'h8,   32'hA5A5_0004, 32'h4,  1, 0);
    vecs[7]  = mk(0, 0, 0, 0,     32'hC,   32'hA5A5_0008, 32'h8,  1, 0);
    vecs[8]  = mk(0, 1, 0, 0,     32'hC,   32'hA5A5_0008, 32'h8,  1, 0);
    vecs[9]  = mk(0, 1, 0, 0,     32'hC,   32'hA5A5_0008, 32'h8,  1, 0);
    vecs[10] = mk(0, 1, 0, 0,     32'hC,   32'hA5A5_0008, 32'h8,  1, 0);
    vecs[11] = mk(0, 1, 0, 0,     32'hC,   32'hA5A5_0008, 32'h8,  1, 1);
    vecs[12] = mk(0, 1, 1, 32'h102, 32'h100, NOP,        32'h0,   0, 1);
    vecs[13] = mk(0, 0, 0, 0,     32'h104, 32'hA5A5_0100, 32'h100, 1, 1);
    vecs[14] = mk(0, 1, 0, 0,     32'h104, 32'hA5A5_0100, 32'h100, 1, 1);
    vecs[15] = mk(1, 1, 1, 32'h80, 32'h0,  NOP,          32'h0,   0, 0);
    vecs[16] = mk(0, 1, 1, 32'h80, 32'h0,  NOP,          32'h0,   0, 0);
    vecs[17] = mk(0, 0, 0, 0,     32'h4,   32'hA5A5_0000, 32'h0,  1, 0);
    vecs[18] = mk(0, 0, 1, 32'h203, 32'h200, NOP,        32'h0,   0, 0);
    vecs[19] = mk(0, 0, 0, 0,     32'h204, 32'hA5A5_0200, 32'h200, 1, 0);

    for (int i = 0; i < 20; i++) begin
      step(vecs[i].r, vecs[i].s, vecs[i].d, vecs[i].p);
      check($sformatf("vec%0d pc", i),    pc,       vecs[i].e_pc);
      check($sformatf("vec%0d inst", i),  if_inst,  vecs[i].e_inst);
      check($sformatf("vec%0d ifpc", i),  if_pc,    vecs[i].e_ifpc);
      check($sformatf("vec%0d ifpc4", i), if_pc4,   vecs[i].e_ifpc + 32'd4);
      check($sformatf("vec%0d valid", i), {31'b0, if_valid}, {31'b0, vecs[i].e_valid});
      check($sformatf("vec%0d err", i),   {31'b0, err}, {31'b0, vecs[i].e_err});
    end

    // PC wrap-around on the instance reset to FFFF_FFF8
    step(1, 0, 0, 0);
    check("wrap rst pc", w_pc, 32'hFFFF_FFF8);
    step(0, 0, 0, 0);
    check("wrap boot pc", w_pc, 32'hFFFF_FFF8);
    check("wrap boot valid", {31'b0, w_valid}, 32'h0);
    step(0, 0, 0, 0);
    check("wrap pc1", w_pc, 32'hFFFF_FFFC);
    check("wrap ifpc1", w_if_pc, 32'hFFFF_FFF8);
    check("wrap inst1", w_if_inst, 32'hFFFF_FFF8 ^ SALT);
    step(0, 0, 0, 0);
    check("wrap pc2", w_pc, 32'h0000_0000);
    check("wrap ifpc2", w_if_pc, 32'hFFFF_FFFC);
    check("wrap ifpc4_2", w_if_pc4, 32'h0000_0000);
    check("wrap err", {31'b0, w_err}, 32'h0);

    // Randomized run against the reference model
    step(1, 0, 0, 0);
    model_edge(1, 0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      logic r, s, d;
      logic [31:0] p;
      r = ($urandom_range(0, 199) == 0);
      s = ($urandom_range(0, 99) < 45);
      d = ($urandom_range(0, 99) < 8);
      p = $urandom;
      step(r, s, d, p);
      model_edge(r, s, d, p);
      check("rnd pc", pc, m_pc);
      check("rnd inst", if_inst, m_inst);
      check("rnd ifpc", if_pc, m_ifpc);
      check("rnd ifpc4", if_pc4, m_ifpc + 32'd4);
      check("rnd valid", {31'b0, if_valid}, {31'b0, m_valid});
      check("rnd err", {31'b0, err}, {31'b0, m_err});
`ifdef FETCH_PERF_CNT_EN
      check("rnd pf_fetch", pf_fetch, m_pf_fetch);
      check("rnd pf_stall", pf_stall, m_pf_stall);
      check("rnd pf_flush", pf_flush, m_pf_flush);
`endif
    end

    // Reset mid-stall with a redirect pending
    step(0, 1, 0, 0);
    model_edge(0, 1, 0, 0);
    step(1, 1, 1, 32'h0000_0300);
    check("rst pc", pc, 32'h0);
    check("rst inst", if_inst, NOP);
    check("rst ifpc", if_pc, 32'h0);
    check("rst ifpc4", if_pc4, 32'h4);
    check("rst valid", {31'b0, if_valid}, 32'h0);
    check("rst err", {31'b0, err}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("rst pf_fetch", pf_fetch, 32'h0);
    check("rst pf_stall", pf_stall, 32'h0);
    check("rst pf_flush", pf_flush, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- PC register and IF/ID pipeline register for the 5-stage RV32I core.
- Drives the instruction-memory address and registers the fetched instruction into ID.
- Consumes data_stall_flag from the data-hazard unit and the redirect from EXE.
- On a stall it holds PC and IF/ID. On a redirect it flushes IF/ID to a NOP bubble.
- Checks that a data stall never exceeds the pipeline's maximum hazard depth.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) loaded on flush and reset.
- MAX_STALL, 3, longest legal run of consecutive data_stall_flag cycles.

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- inst_i  in  32  instruction from combinational imem, addressed by pc_o in the same cycle
- data_stall_flag  in  1  hazard stall request from the data-hazard unit
- redirect_valid  in  1  taken branch/jump resolved in EXE
- redirect_pc  in  32  target address for the redirect
- pc_o  out  32  current fetch address to imem
- if_id_inst_o  out  32  instruction presented to ID
- if_id_pc_o  out  32  PC of if_id_inst_o
- if_id_pc_plus4_o  out  32  if_id_pc_o + 4, for JAL/JALR link
- if_id_valid_o  out  1  1 = real instruction, 0 = bubble
- stall_err_o  out  1  sticky: a stall run exceeded MAX_STALL

Behaviour:
- Reset (rst=1 at edge):
  - pc_o=RESET_PC
  - if_id_inst_o=NOP_INST, if_id_pc_o=0, if_id_pc_plus4_o=4, if_id_valid_o=0
  - stall_err_o=0, stall counter=0, FSM=BOOT
  - Reset overrides every other input. A reset during a stall or redirect discards it fully.
- FSM states:
  - BOOT: one cycle. IF/ID loads NOP, valid=0. PC holds RESET_PC (stall/redirect ignored). Next state RUN.
  - RUN: normal fetch.
    - redirect_valid → FLUSH.
    - else data_stall_flag → STALL.
    - else stay in RUN.
  - STALL: PC and IF/ID hold their values. Stall counter increments.
    - redirect_valid → FLUSH (redirect wins over stall).
    - else data_stall_flag=0 → RUN.
  - FLUSH: entered on the same edge the redirect is taken. Lasts one cycle and is for reporting only; fetch behaves as RUN. Next state follows the RUN rules.
- Per-edge update priority: rst > redirect_valid > data_stall_flag > normal.
  - redirect: pc_o <= {redirect_pc[31:2],2'b00}. IF/ID <= NOP_INST, valid 0, pc fields 0/4.
  - stall: all registers hold.
  - normal: pc_o <= pc_o+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0). IF/ID <= inst_i, pc_o, pc_o+4, valid 1.
- Latency: the instruction at address A appears on if_id_inst_o one cycle after pc_o=A, unless that edge stalls or redirects.
- Stall counter:
  - 2-bit-plus-saturation, counts consecutive stall edges. Clears on any non-stall edge.
  - When the count would reach MAX_STALL+1, stall_err_o <= 1 and stays set until rst. Fetch behaviour is unchanged.
- redirect_valid and data_stall_flag together: redirect taken, stall dropped. The stalled ID instruction is wrong-path.
- redirect_pc with bits[1:0]≠0 is silently aligned. No exception is raised here.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN
- With the macro defined, adds outputs perf_fetch_cnt_o[31:0] (valid instructions loaded into IF/ID), perf_stall_cnt_o[31:0] (stall edges) and perf_flush_cnt_o[31:0] (redirect edges).
  - All three reset to 0 and wrap at 2^32.
  - None of them count during BOOT.
- Without the macro: the ports and counters are absent. All other behaviour is identical.

Decomposition:
- Shared package/header:
  - NOP_INST value
  - FSM state encodings BOOT=2'd0, RUN=2'd1, STALL=2'd2, FLUSH=2'd3
  - RESET_PC default
- One natural sub-module: if_id_reg. It holds the four IF/ID fields with hold/flush/load controls.
- PC register, FSM, stall counter and perf counters live in fetch_stage.

Test Plan:
- Reset then run, with imem returning inst=addr^32'hA5A5_0000:
  - pc_o goes 0,0(BOOT),4,8.
  - if_id_valid_o first goes 1 with if_id_pc_o=0 and if_id_inst_o=32'hA5A5_0000.
- Normal flow to pc_o=8, then data_stall_flag high 3 cycles:
  - pc_o holds 8 and IF/ID holds pc 4 for 3 cycles.
  - Resumes with pc_o=12, stall_err_o=0.
- data_stall_flag high 4 consecutive cycles: stall_err_o=1 after the 4th edge and stays 1 until rst.
- redirect_valid=1, redirect_pc=32'h0000_0102, asserted during a stall:
  - pc_o=32'h100, if_id_inst_o=32'h0000_0013, if_id_valid_o=0.
  - Next edge loads inst for 0x100.
- Reset PC set to 32'hFFFF_FFF8 (RESET_PC): fetch sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, with if_id_pc_plus4_o=0 for the FFFF_FFFC entry.
- rst asserted mid-stall with redirect_valid=1: all outputs return to reset values next edge. With FETCH_PERF_CNT_EN, the counters read 0.
